// File: rtl/mpc_dot_acc.sv
`timescale 1ns/1ps
// Signed dot-product accumulator behind the 4-stage DSP multiplier: sums one row of products, then rounds, scales and range-limits it.
// Optional build macro: MPC_ACC_SAT_EN (clamp to OUT_W and report sat_o; otherwise two's-complement wrap).
module mpc_dot_acc #(
    parameter int MUL_LAT   = 4,
    parameter int PROD_W    = 29,
    parameter int ACC_W     = 40,
    parameter int SHIFT     = 8,
    parameter int OUT_W     = 21,
    parameter int MAX_TERMS = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic                     op_valid,
    input  logic                     op_last,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [OUT_W-1:0]  dout,
    output logic                     dout_vld,
    output logic                     sat_o,
    output logic                     len_err
);

    localparam int CNT_W = ($clog2(MAX_TERMS + 1) > 8) ? $clog2(MAX_TERMS + 1) : 8;
    localparam int RW    = ACC_W - SHIFT + 1;
    localparam logic signed [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                    state;
    logic        [MUL_LAT-1:0] vld_dl;
    logic        [MUL_LAT-1:0] lst_dl;
    logic signed [ACC_W-1:0]   acc;
    logic        [CNT_W-1:0]   cnt;

    logic                      v_a;
    logic                      l_a;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W:0]     rnd_sum;
    logic signed [RW-1:0]      r;
    logic signed [OUT_W-1:0]   res;
    logic                      res_sat;
    logic                      unused_bits;

    assign v_a = vld_dl[MUL_LAT-1];
    assign l_a = lst_dl[MUL_LAT-1];

    // Rounding adds half an LSB of the result before the arithmetic shift (half-up toward +inf).
    always_comb begin
        acc_next = ((state == ACCUM) ? acc : '0) + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        rnd_sum  = {acc_next[ACC_W-1], acc_next} + RND;
        r        = rnd_sum[ACC_W:SHIFT];
`ifdef MPC_ACC_SAT_EN
        res     = r[OUT_W-1:0];
        res_sat = 1'b0;
        if (r > $signed({{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}})) begin
            res     = {1'b0, {(OUT_W-1){1'b1}}};
            res_sat = 1'b1;
        end else if (r < $signed({{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}})) begin
            res     = {1'b1, {(OUT_W-1){1'b0}}};
            res_sat = 1'b1;
        end
        unused_bits = ^rnd_sum[SHIFT-1:0];
`else
        res         = r[OUT_W-1:0];
        res_sat     = 1'b0;
        unused_bits = ^{rnd_sum[SHIFT-1:0], r[RW-1:OUT_W]};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            vld_dl   <= '0;
            lst_dl   <= '0;
            acc      <= '0;
            cnt      <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            sat_o    <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            // NOTE: dout_vld defaults low every clk, not every ce, so the pulse stays one cycle wide even when ce drops.
            dout_vld <= 1'b0;
            if (ce) begin
                vld_dl <= (vld_dl << 1) | MUL_LAT'(op_valid);
                lst_dl <= (lst_dl << 1) | MUL_LAT'(op_valid & op_last);
            end
            if (ce && v_a) begin
                if (cnt == CNT_W'(MAX_TERMS))
                    len_err <= 1'b1;
                if (l_a) begin
                    acc      <= '0;
                    cnt      <= '0;
                    state    <= IDLE;
                    dout     <= res;
                    sat_o    <= res_sat;
                    dout_vld <= 1'b1;
                end else begin
                    acc   <= acc_next;
                    state <= ACCUM;
                    if (cnt != CNT_W'(MAX_TERMS))
                        cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mpc_dot_acc.sv
`timescale 1ns/1ps
// Self-checking bench for mpc_dot_acc: directed cases plus random rows against a row-sum reference model.
module tb_mpc_dot_acc;

    localparam int MUL_LAT   = 4;
    localparam int PROD_W    = 29;
    localparam int ACC_W     = 40;
    localparam int SHIFT     = 8;
    localparam int OUT_W     = 21;
    localparam int MAX_TERMS = 255;
`ifdef MPC_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, ce, op_valid, op_last;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] cur_prod;
    logic signed [PROD_W-1:0] mul_pipe [MUL_LAT];
    logic signed [OUT_W-1:0]  dout;
    logic dout_vld, sat_o, len_err;

    typedef struct {
        longint d;
        bit     s;
    } res_t;

    res_t   exp_q[$];
    longint row_sum = 0;
    int     row_n = 0;
    bit     exp_len = 0;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     vld_count = 0;
    int     issue_cyc = 0;
    longint last_dout = 0;

    mpc_dot_acc #(
        .MUL_LAT(MUL_LAT), .PROD_W(PROD_W), .ACC_W(ACC_W),
        .SHIFT(SHIFT), .OUT_W(OUT_W), .MAX_TERMS(MAX_TERMS)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .op_valid(op_valid), .op_last(op_last),
        .prod(prod), .dout(dout), .dout_vld(dout_vld), .sat_o(sat_o), .len_err(len_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the DSP multiplier: a ce-gated pipe carrying the chosen product values.
    always @(posedge clk) begin
        if (ce) begin
            mul_pipe[0] <= cur_prod;
            for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
        end
    end
    assign prod = mul_pipe[MUL_LAT-1];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic res_t finalize(input longint s);
        res_t   e;
        longint r, w;
        longint hi, lo;
        r  = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        e.s = 1'b0;
        if (SAT_EN) begin
            e.d = r;
            if (r > hi) begin e.d = hi; e.s = 1'b1; end
            else if (r < lo) begin e.d = lo; e.s = 1'b1; end
        end else begin
            w = r & ((longint'(1) <<< OUT_W) - 1);
            if (w > hi) w = w - (longint'(1) <<< OUT_W);
            e.d = w;
        end
        return e;
    endfunction

    // Every result pulse is matched against the oldest row the model has completed.
    initial forever begin
        res_t e;
        @(negedge clk);
        if (dout_vld === 1'b1) begin
            vld_count++;
            last_dout = longint'(dout);
            check("result_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dout", longint'(dout), e.d);
                check("sat_o", longint'(sat_o), longint'(e.s));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input longint p, input bit last, input bit c);
        ce        = c;
        op_valid  = 1'b1;
        op_last   = last;
        cur_prod  = p[PROD_W-1:0];
        issue_cyc = cyc;
        if (c) begin
            row_sum += p;
            row_n++;
            if (row_n > MAX_TERMS) exp_len = 1'b1;
            if (last) begin
                exp_q.push_back(finalize(row_sum));
                row_sum = 0;
                row_n   = 0;
            end
        end
        tick();
        op_valid = 1'b0;
        op_last  = 1'b0;
        cur_prod = PROD_W'($urandom);
    endtask

    task automatic drain;
        int k = 0;
        ce = 1'b1;
        op_valid = 1'b0;
        while (exp_q.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        check("drain", exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic wait_vld(output int seen);
        int k = 0;
        while (dout_vld !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        check("vld_seen", longint'(dout_vld), 1);
        seen = cyc;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        ce = 1'b1;
        op_valid = 1'b0;
        tick();
        tick();
        reset   = 1'b0;
        row_sum = 0;
        row_n   = 0;
        exp_len = 1'b0;
    endtask

    function automatic longint rand_prod();
        logic [PROD_W-1:0] raw;
        case ($urandom_range(0, 3))
            0:       return (longint'(1) <<< (PROD_W - 1)) - 1;
            1:       return -(longint'(1) <<< (PROD_W - 1));
            default: begin
                raw = PROD_W'($urandom);
                return longint'($signed(raw));
            end
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int seen, v0;
        reset = 1'b1; ce = 1'b1; op_valid = 1'b0; op_last = 1'b0; cur_prod = '0;
        repeat (3) tick();
        check("rst_dout", longint'(dout), 0);
        check("rst_vld", longint'(dout_vld), 0);
        check("rst_sat", longint'(sat_o), 0);
        check("rst_len_err", longint'(len_err), 0);
        reset = 1'b0;
        tick();

        // Three-term row with latency and pulse width.
        issue(1000, 0, 1); issue(2000, 0, 1); issue(-500, 1, 1);
        v0 = issue_cyc;
        wait_vld(seen);
        check("lat_3term", seen - v0, MUL_LAT + 1);
        check("dout_3term", longint'(dout), 10);
        check("sat_3term", longint'(sat_o), 0);
        tick();
        check("vld_width", longint'(dout_vld), 0);
        drain();

        // Positive and negative range limits.
        issue((1 <<< 28) - 1, 0, 1); issue((1 <<< 28) - 1, 1, 1);
        wait_vld(seen);
        check("pos_dout", longint'(dout), SAT_EN ? 1048575 : 0);
        check("pos_sat", longint'(sat_o), SAT_EN ? 1 : 0);
        drain();
        issue(-(1 <<< 28), 0, 1); issue(-(1 <<< 28), 1, 1);
        wait_vld(seen);
        check("neg_dout", longint'(dout), SAT_EN ? -1048576 : 0);
        check("neg_sat", longint'(sat_o), SAT_EN ? 1 : 0);
        drain();

        // ce stall of three cycles inside the pipe.
        issue(384, 1, 1);
        v0 = issue_cyc;
        ce = 1'b1; tick();
        ce = 1'b0; repeat (3) tick();
        ce = 1'b1;
        wait_vld(seen);
        check("lat_stall", seen - v0, MUL_LAT + 1 + 3);
        check("dout_stall", longint'(dout), 2);
        ce = 1'b0; tick();
        check("vld_width_ce0", longint'(dout_vld), 0);
        drain();

        // Back-to-back rows.
        v0 = vld_count;
        issue(256, 1, 1); issue(512, 0, 1); issue(512, 1, 1);
        drain();
        check("b2b_pulses", vld_count - v0, 2);
        check("b2b_last", last_dout, 4);

        // Reset mid-row aborts it.
        issue(1000, 0, 1); issue(3000, 0, 1);
        do_reset();
        v0 = vld_count;
        issue(768, 1, 1);
        drain();
        check("rst_row_pulses", vld_count - v0, 1);
        check("rst_row_dout", last_dout, 3);

        // Random rows, ce gaps and valid gaps.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0)
                issue(rand_prod(), $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
            else begin
                ce = ($urandom_range(0, 3) != 0);
                op_valid = 1'b0;
                tick();
            end
        end
        issue(rand_prod(), 1, 1);
        drain();

        // Row length limit.
        do_reset();
        for (int i = 0; i < MAX_TERMS; i++) issue(100, i == MAX_TERMS - 1, 1);
        drain();
        check("len_255", longint'(len_err), longint'(exp_len));
        for (int i = 0; i < MAX_TERMS + 1; i++) issue(-37, i == MAX_TERMS, 1);
        drain();
        check("len_256", longint'(len_err), longint'(exp_len));
        issue(256, 1, 1);
        drain();
        check("len_sticky", longint'(len_err), 1);
        do_reset();
        check("len_cleared", longint'(len_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
